// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- March-style RAM built-in self test controller.
//
// Runs the sequence  W0: w(P) ascending,  R0W1: r(P),w(~P) ascending,
// R1: r(~P) descending  over locations 0 .. test_depth-1. Every pass over
// the array takes test_depth cycles per operation, so a full run lasts
// 4*test_depth cycles from the first W0 cycle until END is entered.
//
// Parameters:
//   addr_size   RAM address width
//   word_size   RAM data width
//   test_depth  number of locations tested (2 .. 2**addr_size)
//   background  March background pattern P
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle request to begin a test
//   ram_addr/ram_data_in/ram_wr/ram_cs   RAM drive (registered)
//   ram_data_out        RAM asynchronous read data at ram_addr
//   busy, done, pass    status; pass is valid while done=1
//   fail_addr           address of the first mismatch
//   err_count           mismatch count, saturating at 16'hFFFF
//
// Build option: define BIST_STOP_ON_FAIL_EN to end the test on the edge
// following the first mismatch instead of running all phases.
module ram_bist_ctrl #(
  parameter int unsigned addr_size  = 16,
  parameter int unsigned word_size  = 8,
  parameter int unsigned test_depth = 1024,
  parameter logic [word_size-1:0] background = 8'h55
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [addr_size-1:0] ram_addr,
  output logic [word_size-1:0] ram_data_in,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [word_size-1:0] ram_data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [addr_size-1:0] fail_addr,
  output logic [15:0]          err_count
);

  localparam logic [addr_size-1:0] LAST  = addr_size'(test_depth - 1);
  localparam logic [addr_size-1:0] ONE   = addr_size'(1);
  localparam logic [word_size-1:0] PAT   = background;
  localparam logic [word_size-1:0] PAT_N = ~background;

  localparam bit STOP_ON_FAIL =
`ifdef BIST_STOP_ON_FAIL_EN
    1'b1;
`else
    1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, W0, R0W1_RD, R0W1_WR, R1, END
  } state_t;

  state_t      state;
  logic        mismatch;
  logic [15:0] err_next;

  // ram_addr doubles as the March address counter; the read compare uses the
  // registered address, so the RAM's async data is checked in the same cycle.
  always_comb begin
    mismatch = 1'b0;
    case (state)
      R0W1_RD: mismatch = (ram_data_out != PAT);
      R1:      mismatch = (ram_data_out != PAT_N);
      default: mismatch = 1'b0;
    endcase
    err_next = err_count;
    if (mismatch && (err_count != '1))
      err_next = err_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      err_count   <= '0;
      ram_cs      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0)
          fail_addr <= ram_addr;
      end

      case (state)
        IDLE: begin
          if (start && !busy) begin
            state       <= W0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            err_count   <= '0;
            ram_cs      <= 1'b1;
            ram_wr      <= 1'b1;
            ram_addr    <= '0;
            ram_data_in <= PAT;
          end
        end

        W0: begin
          if (ram_addr == LAST) begin
            state       <= R0W1_RD;
            ram_addr    <= '0;
            ram_wr      <= 1'b0;
            ram_data_in <= '0;
          end else begin
            ram_addr <= ram_addr + ONE;
          end
        end

        R0W1_RD: begin
          if (STOP_ON_FAIL && mismatch) begin
            state       <= END;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            ram_cs      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
          end else begin
            state       <= R0W1_WR;
            ram_wr      <= 1'b1;
            ram_data_in <= PAT_N;
          end
        end

        R0W1_WR: begin
          ram_wr      <= 1'b0;
          ram_data_in <= '0;
          // R1 begins at the top address, which is where this phase ends.
          if (ram_addr == LAST) begin
            state <= R1;
          end else begin
            state    <= R0W1_RD;
            ram_addr <= ram_addr + ONE;
          end
        end

        R1: begin
          if ((STOP_ON_FAIL && mismatch) || (ram_addr == '0)) begin
            state       <= END;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= (err_next == '0);
            ram_cs      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
          end else begin
            ram_addr <= ram_addr - ONE;
          end
        end

        END: begin
          // start is not accepted in this cycle; status is held in IDLE.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

  localparam logic [7:0] P     = 8'h55;
  localparam logic [7:0] P_N   = 8'hAA;
  localparam int         DEPTH = 16;
  localparam int         GUARD = 400;

  localparam bit STOP =
`ifdef BIST_STOP_ON_FAIL_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
  } acc_t;

  typedef struct {
    int unsigned err;
    int unsigned fail;
    int unsigned len;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic        ram_wr;
  logic        ram_cs;
  logic [7:0]  ram_data_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] fail_addr;
  logic [15:0] err_count;

  int compared   = 0;
  int mismatched = 0;

  acc_t acc_q[$];
  res_t res_q[$];

  // RAM model with fault injection
  logic [7:0] mem [DEPTH];
  logic [7:0] stuck_or;
  logic       corrupt_arm;

  ram_bist_ctrl #(.test_depth(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_wr       (ram_wr),
    .ram_cs       (ram_cs),
    .ram_data_out (ram_data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background writes to address 5 are stored as 0x00 when armed, so the
  // word is corrupt after W0 while the later ~P write lands normally.
  always @(posedge clk) begin
    if (ram_cs && ram_wr) begin
      if (corrupt_arm && ram_addr == 16'd5 && ram_data_in == P)
        mem[5] <= 8'h00;
      else
        mem[ram_addr[3:0]] <= ram_data_in;
    end
  end

  assign ram_data_out = mem[ram_addr[3:0]] | stuck_or;

  // Access scoreboard: every RAM access must match the next expected one.
  always @(negedge clk) begin
    if (ram_wr && !ram_cs) begin
      compared++; mismatched++;
      $display("FAIL wr_without_cs: ram_wr=%b ram_cs=%b required ram_wr=0", ram_wr, ram_cs);
    end
    if (ram_cs) begin
      if (acc_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_access: addr=%0d wr=%b, required no access", ram_addr, ram_wr);
      end else begin
        acc_t e;
        e = acc_q.pop_front();
        compared++;
        if (ram_addr !== e.addr || ram_wr !== e.wr) begin
          mismatched++;
          $display("FAIL access_op: addr=%0d wr=%b, required addr=%0d wr=%b",
                   ram_addr, ram_wr, e.addr, e.wr);
        end
        if (e.wr) begin
          compared++;
          if (ram_data_in !== e.data) begin
            mismatched++;
            $display("FAIL access_data: addr=%0d data=%h, required %h", ram_addr, ram_data_in, e.data);
          end
        end
      end
    end
  end

  function automatic void push_acc(input int a, input logic wr, input logic [7:0] d);
    acc_t e;
    e.addr = 16'(a);
    e.wr   = wr;
    e.data = d;
    acc_q.push_back(e);
  endfunction

  // Reference March run against a behavioural faulty memory.
  task automatic expect_run(input logic [7:0] stuck, input bit corrupt);
    logic [7:0] mm [DEPTH];
    logic [7:0] rd;
    res_t r;
    bit stop;
    r.err = 0; r.fail = 0; r.len = 0; stop = 0;
    for (int a = 0; a < DEPTH; a++) begin
      push_acc(a, 1'b1, P); r.len++;
      mm[a] = (corrupt && a == 5) ? 8'h00 : P;
    end
    for (int a = 0; a < DEPTH && !stop; a++) begin
      push_acc(a, 1'b0, 8'h00); r.len++;
      rd = mm[a] | stuck;
      if (rd != P) begin
        if (r.err == 0) r.fail = a;
        r.err++;
        if (STOP) stop = 1;
      end
      if (!stop) begin
        push_acc(a, 1'b1, P_N); r.len++;
        mm[a] = P_N;
      end
    end
    for (int a = DEPTH - 1; a >= 0 && !stop; a--) begin
      push_acc(a, 1'b0, 8'h00); r.len++;
      rd = mm[a] | stuck;
      if (rd != P_N) begin
        if (r.err == 0) r.fail = a;
        r.err++;
        if (STOP) stop = 1;
      end
    end
    res_q.push_back(r);
  endtask

  // Pulses start, optionally re-pulses or resets at a given busy cycle,
  // then checks the final status against the popped expectation.
  task automatic run_test(input string name, input int repulse_at, input int reset_at);
    int   cnt;
    int   guard;
    res_t e;
    cnt = 0; guard = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    compared++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
    while (!done && guard < GUARD) begin
      if (busy) cnt++;
      start = (cnt == repulse_at);
      if (reset_at > 0 && cnt == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_cs !== 1'b0) begin
          mismatched++;
          $display("FAIL %s_abort: busy=%b done=%b ram_cs=%b, required 0 0 0", name, busy, done, ram_cs);
        end
        acc_q.delete();
        void'(res_q.pop_front());
        repeat (3) @(negedge clk);
        return;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    e = res_q.pop_front();
    compared++;
    if (guard >= GUARD) begin
      mismatched++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required done=1", name, done, guard);
    end
    compared++;
    if (cnt != int'(e.len)) begin
      mismatched++;
      $display("FAIL %s_length: busy cycles=%0d, required %0d", name, cnt, e.len);
    end
    compared++;
    if (busy !== 1'b0 || pass !== (e.err == 0)) begin
      mismatched++;
      $display("FAIL %s_status: busy=%b pass=%b, required busy=0 pass=%b", name, busy, pass, e.err == 0);
    end
    compared++;
    if (err_count !== 16'(e.err)) begin
      mismatched++;
      $display("FAIL %s_err_count: got %0d, required %0d", name, err_count, e.err);
    end
    compared++;
    if (fail_addr !== 16'(e.fail)) begin
      mismatched++;
      $display("FAIL %s_fail_addr: got %0d, required %0d", name, fail_addr, e.fail);
    end
    compared++;
    if (acc_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_missing_access: %0d accesses left, required 0", name, acc_q.size());
    end
    acc_q.delete();
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || ram_cs !== 1'b0 || ram_wr !== 1'b0 ||
        ram_addr !== 16'h0 || ram_data_in !== 8'h00 || err_count !== 16'(e.err)) begin
      mismatched++;
      $display("FAIL %s_idle_hold: done=%b cs=%b wr=%b addr=%0d din=%h err=%0d, required 1 0 0 0 00 %0d",
               name, done, ram_cs, ram_wr, ram_addr, ram_data_in, err_count, e.err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_status: busy=%b done=%b pass=%b, required 0 0 0", busy, done, pass);
    end
    compared++;
    if (fail_addr !== 16'h0 || err_count !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_counters: fail_addr=%0d err=%0d, required 0 0", fail_addr, err_count);
    end
    compared++;
    if (ram_cs !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 16'h0 || ram_data_in !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_ram: cs=%b wr=%b addr=%0d din=%h, required 0 0 0 00",
               ram_cs, ram_wr, ram_addr, ram_data_in);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    stuck_or = 8'h00; corrupt_arm = 1'b0;
    expect_run(8'h00, 1'b0);
    run_test("clean", -1, 0);
  endtask

  task automatic test_stuck_bit();
    stuck_or = 8'h01; corrupt_arm = 1'b0;
    expect_run(8'h01, 1'b0);
    run_test("stuck_bit0", -1, 0);
    stuck_or = 8'h00;
  endtask

  task automatic test_corrupt_word();
    stuck_or = 8'h00; corrupt_arm = 1'b1;
    expect_run(8'h00, 1'b1);
    run_test("corrupt5", -1, 0);
    corrupt_arm = 1'b0;
  endtask

  task automatic test_restart_ignored();
    expect_run(8'h00, 1'b0);
    run_test("repulse", 10, 0);
  endtask

  task automatic test_reset_mid();
    expect_run(8'h00, 1'b0);
    run_test("reset_mid", -1, 30);
    expect_run(8'h00, 1'b0);
    run_test("after_reset", -1, 0);
  endtask

  task automatic test_back_to_back();
    expect_run(8'h00, 1'b1);
    corrupt_arm = 1'b1;
    run_test("b2b_first", -1, 0);
    corrupt_arm = 1'b0;
    expect_run(8'h00, 1'b0);
    run_test("b2b_second", -1, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stuck_or = 8'h00; corrupt_arm = 1'b0;
    test_reset();
    test_clean();
    test_stuck_bit();
    test_corrupt_word();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
